// File: rtl/abus_req_agent_pkg.sv
// Shared abus definitions: agent state encoding and default bus widths.
package abus_req_agent_pkg;

  localparam int ABUS_AW = 16;
  localparam int ABUS_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } abus_state_t;

endpackage

// File: rtl/abus_req_agent_if.sv
// Local command/response, arbiter handshake and bus beat signals of one master.
interface abus_req_agent_if #(
  parameter int AW = abus_req_agent_pkg::ABUS_AW,
  parameter int DW = abus_req_agent_pkg::ABUS_DW
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_wr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          req;
  logic          grant;
  logic          bus_valid;
  logic [AW-1:0] bus_addr;
  logic          bus_wr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  // agent side
  modport master (
    input  cmd_valid, cmd_addr, cmd_wr, cmd_wdata, grant, bus_ack, bus_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, req,
           bus_valid, bus_addr, bus_wr, bus_wdata
  );

  // local master logic, arbiter and target side
  modport slave (
    output cmd_valid, cmd_addr, cmd_wr, cmd_wdata, grant, bus_ack, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, req,
           bus_valid, bus_addr, bus_wr, bus_wdata
  );
endinterface

// File: rtl/abus_req_agent_tmo.sv
// Clear/enable/expire counter; expired flags the LIMIT-th counted cycle.
module abus_tmo_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  // count enabled cycles, holding at all-ones so it can never wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == LAST);
endmodule

// File: rtl/abus_req_agent.sv
// Requester-side abus agent: one-entry command register, arbiter request,
// bounded grant tenure and per-beat ack timeout.
//
// state | meaning
// IDLE  | ready for a command, no request
// REQ   | command held, req raised, waiting for grant
// XFER  | beat on bus while granted; back-to-back beats until hold limit
// REL   | req dropped for one cycle so the arbiter rotates
module abus_req_agent
  import abus_req_agent_pkg::*;
#(
  parameter int AW       = ABUS_AW,
  parameter int DW       = ABUS_DW,
  parameter int MAX_HOLD = 4,
  parameter int TMO      = 255
) (
  input  logic             clk,
  input  logic             rstn,
  abus_req_agent_if.master ab
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW:0] HOLD_LIM = (HW + 1)'(MAX_HOLD);

  abus_state_t   state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic [DW-1:0] wdata_q;
  logic [HW-1:0] hold_q;
  logic [HW:0]   hold_nxt;
  logic          rsp_valid_q, rsp_err_q;
  logic [DW-1:0] rsp_rdata_q;

  logic ack_eff, tmo_exp, tmo_clr, tmo_en;
  logic accept, hold_clr, hold_inc, rsp_fire, rsp_err_d, cmd_ready;

  // an ack only counts while the beat is actually driven on the bus
  assign ack_eff  = (state_q == XFER) && ab.grant && ab.bus_ack;
  assign hold_nxt = {1'b0, hold_q} + (HW + 1)'(1);

  abus_tmo_cnt #(.LIMIT(TMO)) u_tmo (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and per-cycle control; ack beats timeout on the expiry cycle
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    hold_clr  = 1'b0;
    hold_inc  = 1'b0;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;
    rsp_fire  = 1'b0;
    rsp_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (ab.cmd_valid) begin
          accept   = 1'b1;
          hold_clr = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ab.grant) begin
          tmo_clr = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ack_eff) begin
          rsp_fire = 1'b1;
          hold_inc = 1'b1;
          if (ab.cmd_valid && (hold_nxt < HOLD_LIM)) begin
            cmd_ready = 1'b1;
            accept    = 1'b1;
            tmo_clr   = 1'b1;
          end else begin
            state_d = REL;
          end
        end else if (tmo_exp) begin
          rsp_fire  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = REL;
        end else begin
          tmo_en = 1'b1;
        end
      end
      REL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // command register, tenure beat count and response register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      hold_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= ab.cmd_addr;
        wr_q    <= ab.cmd_wr;
        wdata_q <= ab.cmd_wdata;
      end
      if (hold_clr)                       hold_q <= '0;
      else if (hold_inc && hold_q != '1)  hold_q <= hold_nxt[HW-1:0];
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_err_q   <= rsp_err_d;
        rsp_rdata_q <= (wr_q || rsp_err_d) ? '0 : ab.bus_rdata;
      end
    end
  end

  assign ab.cmd_ready = cmd_ready;
  assign ab.req       = (state_q == REQ) || (state_q == XFER);
  assign ab.bus_valid = (state_q == XFER) && ab.grant;
  assign ab.bus_addr  = addr_q;
  assign ab.bus_wr    = wr_q;
  assign ab.bus_wdata = wdata_q;
  assign ab.rsp_valid = rsp_valid_q;
  assign ab.rsp_err   = rsp_err_q;
  assign ab.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_abus_req_agent.sv
// Directed bench for abus_req_agent with MAX_HOLD=4, TMO=8.
module tb_abus_req_agent;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  abus_req_agent_if #(.AW(16), .DW(32)) ab ();

  abus_req_agent #(.AW(16), .DW(32), .MAX_HOLD(4), .TMO(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .ab   (ab)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command from IDLE with grant held high except during the
  // stall window; cycle n=0 is the accept cycle, r = n-2 is the XFER offset.
  task automatic beat_run(
    input  logic [15:0] addr, input logic wr, input logic [31:0] wdata,
    input  int stall_start, input int stall_len, input int ack_at,
    input  logic [31:0] ack_rdata,
    output int first_bv, output int rsp_n, output logic err,
    output logic [31:0] rdata, output logic req_at_rsp,
    output logic ready_after, output int stall_bv_hi,
    output logic [15:0] addr_obs, output logic wr_obs, output logic [31:0] wdata_obs);
    int r;
    first_bv = -1; rsp_n = -1; err = 1'bx; rdata = 'x; req_at_rsp = 1'bx;
    ready_after = 1'b0; stall_bv_hi = 0; addr_obs = 'x; wr_obs = 1'bx; wdata_obs = 'x;
    ab.cmd_valid = 1'b1; ab.cmd_addr = addr; ab.cmd_wr = wr; ab.cmd_wdata = wdata;
    ab.grant = 1'b1; ab.bus_ack = 1'b0;
    for (int n = 1; n <= 40 && rsp_n < 0; n++) begin
      tick();
      ab.cmd_valid = 1'b0;
      r = n - 2;
      ab.grant     = !(r >= stall_start && r < stall_start + stall_len);
      ab.bus_ack   = (r == ack_at);
      ab.bus_rdata = (r == ack_at) ? ack_rdata : 32'h1234_5678;
      #1;
      if (ab.bus_valid && first_bv < 0) begin
        first_bv = n; addr_obs = ab.bus_addr; wr_obs = ab.bus_wr; wdata_obs = ab.bus_wdata;
      end
      if (ab.bus_valid && r >= stall_start && r < stall_start + stall_len) stall_bv_hi++;
      if (ab.rsp_valid) begin
        rsp_n = n; err = ab.rsp_err; rdata = ab.rsp_rdata; req_at_rsp = ab.req;
      end
    end
    ab.grant = 1'b0; ab.bus_ack = 1'b0;
    tick();
    ready_after = ab.cmd_ready;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ab.cmd_valid = 1'b0; ab.cmd_addr = '0; ab.cmd_wr = 1'b0; ab.cmd_wdata = '0;
    ab.grant = 1'b0; ab.bus_ack = 1'b0; ab.bus_rdata = '0;
    repeat (3) tick();
    checks++; if (ab.req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", ab.req); end
    checks++; if (ab.bus_valid !== 1'b0) begin failures++; $display("FAIL reset_bus_valid: got %b expected 0", ab.bus_valid); end
    checks++; if (ab.rsp_valid !== 1'b0 || ab.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp: got valid=%b err=%b expected 0/0", ab.rsp_valid, ab.rsp_err); end
    checks++; if (ab.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", ab.rsp_rdata); end
    checks++; if ({ab.bus_addr, ab.bus_wr, ab.bus_wdata} !== 49'h0) begin failures++; $display("FAIL reset_bus_regs: got %h/%b/%h expected 0", ab.bus_addr, ab.bus_wr, ab.bus_wdata); end
    rstn = 1'b1;
    tick();
    checks++; if (ab.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_ready: got %b expected 1", ab.cmd_ready); end
  endtask

  task automatic test_single_read();
    ab.cmd_valid = 1'b1; ab.cmd_addr = 16'h0010; ab.cmd_wr = 1'b0; ab.cmd_wdata = '0;
    ab.grant = 1'b0; ab.bus_ack = 1'b0;
    #1;
    checks++; if (ab.cmd_ready !== 1'b1) begin failures++; $display("FAIL rd_accept: got %b expected 1", ab.cmd_ready); end
    tick(); ab.cmd_valid = 1'b0; #1;
    checks++; if (ab.req !== 1'b1 || ab.cmd_ready !== 1'b0) begin failures++; $display("FAIL rd_req: got req=%b ready=%b expected 1/0", ab.req, ab.cmd_ready); end
    checks++; if (ab.bus_addr !== 16'h0010) begin failures++; $display("FAIL rd_addr: got %h expected 0010", ab.bus_addr); end
    tick();
    checks++; if (ab.req !== 1'b1 || ab.bus_valid !== 1'b0) begin failures++; $display("FAIL rd_wait_grant: got req=%b bv=%b expected 1/0", ab.req, ab.bus_valid); end
    ab.grant = 1'b1;
    tick();
    checks++; if (ab.bus_valid !== 1'b1) begin failures++; $display("FAIL rd_bus_valid: got %b expected 1", ab.bus_valid); end
    tick(); tick();
    checks++; if (ab.rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_early_rsp: got %b expected 0", ab.rsp_valid); end
    ab.bus_ack = 1'b1; ab.bus_rdata = 32'hDEAD_BEEF;
    tick();
    ab.bus_ack = 1'b0; ab.grant = 1'b0; ab.bus_rdata = '0; #1;
    checks++; if (ab.rsp_valid !== 1'b1 || ab.rsp_err !== 1'b0) begin failures++; $display("FAIL rd_rsp: got valid=%b err=%b expected 1/0", ab.rsp_valid, ab.rsp_err); end
    checks++; if (ab.rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata: got %h expected deadbeef", ab.rsp_rdata); end
    checks++; if (ab.req !== 1'b0 || ab.cmd_ready !== 1'b0) begin failures++; $display("FAIL rd_rel: got req=%b ready=%b expected 0/0", ab.req, ab.cmd_ready); end
    tick();
    checks++; if (ab.rsp_valid !== 1'b0 || ab.req !== 1'b0 || ab.cmd_ready !== 1'b1) begin failures++; $display("FAIL rd_idle: got rv=%b req=%b ready=%b expected 0/0/1", ab.rsp_valid, ab.req, ab.cmd_ready); end
  endtask

  task automatic test_hold_limit();
    logic [31:0] wtab [6];
    int exp_beat [6];
    int beat_n [8];
    logic [31:0] beat_d [8];
    logic req_log [20];
    int idx, nb, nr, bad;
    wtab = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005, 32'h6666_0006};
    exp_beat = '{2, 3, 4, 5, 9, 10};
    idx = 0; nb = 0; nr = 0; bad = 0;
    for (int n = 0; n < 20; n++) begin
      ab.cmd_valid = (idx < 6);
      ab.cmd_addr  = 16'h0100 + 16'(idx);
      ab.cmd_wr    = 1'b1;
      ab.cmd_wdata = wtab[(idx < 6) ? idx : 5];
      ab.grant = 1'b1; ab.bus_ack = 1'b1; ab.bus_rdata = 32'hA5A5_A5A5;
      #1;
      if (ab.bus_valid && nb < 8) begin beat_n[nb] = n; beat_d[nb] = ab.bus_wdata; nb++; end
      if (ab.rsp_valid) begin nr++; if (ab.rsp_err !== 1'b0 || ab.rsp_rdata !== 32'h0) bad++; end
      req_log[n] = ab.req;
      if (ab.cmd_valid && ab.cmd_ready) idx++;
      tick();
    end
    ab.cmd_valid = 1'b0; ab.grant = 1'b0; ab.bus_ack = 1'b0;
    tick();
    checks++; if (nb !== 6) begin failures++; $display("FAIL hold_beats: got %0d expected 6", nb); end
    checks++; if (nr !== 6 || bad !== 0) begin failures++; $display("FAIL hold_rsps: got %0d rsps %0d bad expected 6/0", nr, bad); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= nb || beat_n[i] !== exp_beat[i] || beat_d[i] !== wtab[i]) begin
        failures++;
        $display("FAIL hold_beat%0d: got cycle %0d data %h expected cycle %0d data %h", i, (i < nb) ? beat_n[i] : -1, (i < nb) ? beat_d[i] : 32'h0, exp_beat[i], wtab[i]);
      end
    end
    checks++; if (req_log[6] !== 1'b0 || req_log[5] !== 1'b1) begin failures++; $display("FAIL hold_release: got req5=%b req6=%b expected 1/0", req_log[5], req_log[6]); end
  endtask

  task automatic test_timeout();
    int fb, rn, sh; logic e, rq, ra, w; logic [31:0] d, wd; logic [15:0] a;
    beat_run(16'h0020, 1'b0, 32'h0, -100, 0, -100, 32'h0, fb, rn, e, d, rq, ra, sh, a, w, wd);
    checks++; if (fb !== 2) begin failures++; $display("FAIL tmo_bv_latency: got %0d expected 2", fb); end
    checks++; if (rn !== 10) begin failures++; $display("FAIL tmo_rsp_cycle: got %0d expected 10", rn); end
    checks++; if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL tmo_rsp: got err=%b rdata=%h expected 1/0", e, d); end
    checks++; if (rq !== 1'b0 || ra !== 1'b1) begin failures++; $display("FAIL tmo_rel_idle: got req=%b ready=%b expected 0/1", rq, ra); end
  endtask

  task automatic test_ack_on_expiry();
    int fb, rn, sh; logic e, rq, ra, w; logic [31:0] d, wd; logic [15:0] a;
    beat_run(16'h0030, 1'b0, 32'h0, -100, 0, 7, 32'hCAFE_F00D, fb, rn, e, d, rq, ra, sh, a, w, wd);
    checks++; if (rn !== 10) begin failures++; $display("FAIL exp_rsp_cycle: got %0d expected 10", rn); end
    checks++; if (e !== 1'b0 || d !== 32'hCAFE_F00D) begin failures++; $display("FAIL exp_rsp: got err=%b rdata=%h expected 0/cafef00d", e, d); end
  endtask

  task automatic test_write();
    int fb, rn, sh; logic e, rq, ra, w; logic [31:0] d, wd; logic [15:0] a;
    beat_run(16'hBEE0, 1'b1, 32'h5A5A_1234, -100, 0, 0, 32'hFFFF_FFFF, fb, rn, e, d, rq, ra, sh, a, w, wd);
    checks++; if (a !== 16'hBEE0 || w !== 1'b1 || wd !== 32'h5A5A_1234) begin failures++; $display("FAIL wr_bus: got %h/%b/%h expected bee0/1/5a5a1234", a, w, wd); end
    checks++; if (rn !== 3 || e !== 1'b0 || d !== 32'h0) begin failures++; $display("FAIL wr_rsp: got cyc=%0d err=%b rdata=%h expected 3/0/0", rn, e, d); end
  endtask

  task automatic test_grant_drop_timeout();
    int fb, rn, sh; logic e, rq, ra, w; logic [31:0] d, wd; logic [15:0] a;
    // ack raised while grant is low must be ignored; stalled cycles still count
    beat_run(16'h0040, 1'b0, 32'h0, 1, 3, 2, 32'h7777_7777, fb, rn, e, d, rq, ra, sh, a, w, wd);
    checks++; if (sh !== 0) begin failures++; $display("FAIL gdt_stall_bv: got %0d high cycles expected 0", sh); end
    checks++; if (rn !== 10 || e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL gdt_rsp: got cyc=%0d err=%b rdata=%h expected 10/1/0", rn, e, d); end
  endtask

  task automatic test_grant_drop();
    int fb, rn, sh; logic e, rq, ra, w; logic [31:0] d, wd; logic [15:0] a;
    beat_run(16'h0050, 1'b0, 32'h0, 1, 3, 5, 32'h0BAD_CAFE, fb, rn, e, d, rq, ra, sh, a, w, wd);
    checks++; if (sh !== 0) begin failures++; $display("FAIL gd_stall_bv: got %0d high cycles expected 0", sh); end
    checks++; if (rn !== 8 || e !== 1'b0 || d !== 32'h0BAD_CAFE) begin failures++; $display("FAIL gd_rsp: got cyc=%0d err=%b rdata=%h expected 8/0/0badcafe", rn, e, d); end
  endtask

  task automatic test_reset_mid_xfer();
    int fb, rn, sh, pulses; logic e, rq, ra, w; logic [31:0] d, wd; logic [15:0] a;
    ab.cmd_valid = 1'b1; ab.cmd_addr = 16'h0055; ab.cmd_wr = 1'b1; ab.cmd_wdata = 32'h9999_0000;
    ab.grant = 1'b1; ab.bus_ack = 1'b0;
    tick(); ab.cmd_valid = 1'b0;
    tick();
    checks++; if (ab.bus_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_bv: got %b expected 1", ab.bus_valid); end
    ab.bus_ack = 1'b1; ab.bus_rdata = 32'h7777_7777;
    rstn = 1'b0;
    #1;
    checks++; if (ab.req !== 1'b0 || ab.bus_valid !== 1'b0) begin failures++; $display("FAIL rst_async: got req=%b bv=%b expected 0/0", ab.req, ab.bus_valid); end
    checks++; if (ab.rsp_rdata !== 32'h0 || ab.bus_addr !== 16'h0 || ab.bus_wdata !== 32'h0 || ab.bus_wr !== 1'b0) begin failures++; $display("FAIL rst_regs: got rdata=%h addr=%h wdata=%h wr=%b expected 0", ab.rsp_rdata, ab.bus_addr, ab.bus_wdata, ab.bus_wr); end
    pulses = 0;
    repeat (2) begin tick(); if (ab.rsp_valid !== 1'b0) pulses++; end
    ab.bus_ack = 1'b0; ab.grant = 1'b0;
    rstn = 1'b1;
    tick();
    if (ab.rsp_valid !== 1'b0) pulses++;
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_no_rsp: got %0d pulses expected 0", pulses); end
    checks++; if (ab.cmd_ready !== 1'b1 || ab.req !== 1'b0) begin failures++; $display("FAIL rst_idle: got ready=%b req=%b expected 1/0", ab.cmd_ready, ab.req); end
    beat_run(16'h0066, 1'b0, 32'h0, -100, 0, 1, 32'h1357_9BDF, fb, rn, e, d, rq, ra, sh, a, w, wd);
    checks++; if (a !== 16'h0066 || rn !== 4 || e !== 1'b0 || d !== 32'h1357_9BDF) begin failures++; $display("FAIL rst_recover: got addr=%h cyc=%0d err=%b rdata=%h expected 0066/4/0/13579bdf", a, rn, e, d); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_hold_limit();
    test_timeout();
    test_ack_on_expiry();
    test_write();
    test_grant_drop_timeout();
    test_grant_drop();
    test_reset_mid_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end
endmodule
